lut_sweep_reader: RTL and testbench

Readback engine for truth-table neurons. Drives every input code `0 .. 2^IN_BITS-1` into one attached LUT neuron, captures each output, and packs the results LSB-first into `WORD_W`-bit words. The words go out on a valid/ready stream. It sits beside the generated neuron layers, for on-chip dump and check of synthesized LUT contents against the trained model.

---
 rtl/lut_sweep_reader.sv | 168 ++++++++++++++++
 tb/tb_lut_sweep_reader.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lut_sweep_reader.sv
// lut_sweep_reader: drives every input code into one LUT neuron and streams the captured outputs packed LSB-first.
// Optional feature: define LUT_SWEEP_POPCOUNT_EN to append one word holding the count of nonzero entries.
module lut_sweep_reader #(
  parameter int unsigned IN_BITS     = 8,
  parameter int unsigned OUT_BITS    = 1,
  parameter int unsigned WORD_W      = 32,
  parameter int unsigned LUT_LATENCY = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [IN_BITS-1:0]  lut_in,
  input  logic [OUT_BITS-1:0] lut_out,
  output logic [WORD_W-1:0]   m_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic                m_last
);

  localparam int unsigned EPW    = WORD_W / OUT_BITS;
  localparam int unsigned IDX_W  = IN_BITS + 1;
  localparam int unsigned SLOT_W = (EPW > 1) ? $clog2(EPW) : 1;
  localparam int unsigned WCNT_W = (LUT_LATENCY > 1) ? $clog2(LUT_LATENCY) : 1;
  localparam int unsigned WLAST  = (LUT_LATENCY > 0) ? LUT_LATENCY - 1 : 0;

  localparam logic [IDX_W-1:0]  LAST_IDX  = {1'b0, {IN_BITS{1'b1}}};
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(EPW - 1);
  localparam logic [WCNT_W-1:0] LAST_WCNT = WCNT_W'(WLAST);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_WAIT,
    S_EMIT,
    S_FIN
  } state_t;

  state_t              state;
  logic [IDX_W-1:0]    idx;
  logic [SLOT_W-1:0]   slot;
  logic [WCNT_W-1:0]   wcnt;
  logic [WORD_W-1:0]   pack;

`ifdef LUT_SWEEP_POPCOUNT_EN
  logic [IDX_W-1:0]    pcnt;
  logic                pc_sent;
`endif

  logic                cap_c;
  logic                last_entry_c;
  logic                word_full_c;
  logic [IDX_W-1:0]    idx_nx_c;
  logic [WORD_W-1:0]   cap_pack_c;

  // Capture strobe and the pack word with the current entry merged into its slot
  always_comb begin
    cap_c        = ((state == S_DRIVE) && (LUT_LATENCY == 0)) ||
                   ((state == S_WAIT) && (wcnt == LAST_WCNT));
    last_entry_c = (idx == LAST_IDX);
    word_full_c  = (slot == LAST_SLOT);
    idx_nx_c     = idx + 1'b1;
    cap_pack_c   = pack;
    for (int unsigned s = 0; s < EPW; s++) begin
      if (slot == SLOT_W'(s)) cap_pack_c[s*OUT_BITS +: OUT_BITS] = lut_out;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      idx     <= '0;
      slot    <= '0;
      wcnt    <= '0;
      pack    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      lut_in  <= '0;
      m_data  <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
`ifdef LUT_SWEEP_POPCOUNT_EN
      pcnt    <= '0;
      pc_sent <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state  <= S_DRIVE;
            idx    <= '0;
            slot   <= '0;
            pack   <= '0;
            busy   <= 1'b1;
            lut_in <= '0;
`ifdef LUT_SWEEP_POPCOUNT_EN
            pcnt    <= '0;
            pc_sent <= 1'b0;
`endif
          end
        end
        S_DRIVE: begin
          if (!cap_c) begin
            state <= S_WAIT;
            wcnt  <= '0;
          end
        end
        S_WAIT: begin
          if (!cap_c) wcnt <= wcnt + 1'b1;
        end
        S_EMIT: begin
          // lut_in is left untouched here so the neuron input stays frozen while stalled
          if (m_ready) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            pack    <= '0;
            slot    <= '0;
            if (!last_entry_c) begin
              idx    <= idx_nx_c;
              lut_in <= idx_nx_c[IN_BITS-1:0];
              state  <= S_DRIVE;
            end
`ifdef LUT_SWEEP_POPCOUNT_EN
            else if (!pc_sent) begin
              m_valid <= 1'b1;
              m_last  <= 1'b1;
              m_data  <= WORD_W'(pcnt);
              pc_sent <= 1'b1;
            end
`endif
            else begin
              state <= S_FIN;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      if (cap_c) begin
        pack <= cap_pack_c;
`ifdef LUT_SWEEP_POPCOUNT_EN
        pcnt <= pcnt + IDX_W'(|lut_out);
`endif
        if (word_full_c || last_entry_c) begin
          state   <= S_EMIT;
          m_valid <= 1'b1;
          m_data  <= cap_pack_c;
`ifdef LUT_SWEEP_POPCOUNT_EN
          m_last  <= 1'b0;
`else
          m_last  <= last_entry_c;
`endif
        end else begin
          idx    <= idx_nx_c;
          slot   <= slot + 1'b1;
          lut_in <= idx_nx_c[IN_BITS-1:0];
          state  <= S_DRIVE;
        end
      end
    end
  end

endmodule

// File: tb/tb_lut_sweep_reader.sv
// tb_lut_sweep_reader: scoreboard bench with a combinational-LUT instance and a 2-stage registered-LUT instance.
module tb_lut_sweep_reader;

`ifdef LUT_SWEEP_POPCOUNT_EN
  localparam bit POP = 1'b1;
`else
  localparam bit POP = 1'b0;
`endif
  localparam int NW = 8 + int'(POP);

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } word_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int   mode_a = 0;
  int   mode_b = 3;
  logic tbl [256];
  bit   ready_rand_a = 1'b0;
  bit   ready_rand_b = 1'b0;

  logic        rst_a = 1'b1, start_a = 1'b0, m_ready_a = 1'b1;
  logic        busy_a, done_a, m_valid_a, m_last_a;
  logic [7:0]  lut_in_a;
  logic [0:0]  lut_out_a;
  logic [31:0] m_data_a;

  logic        rst_b = 1'b1, start_b = 1'b0, m_ready_b = 1'b1;
  logic        busy_b, done_b, m_valid_b, m_last_b;
  logic [7:0]  lut_in_b;
  logic [0:0]  lut_out_b;
  logic [31:0] m_data_b;
  logic        sb1 = 1'b0, sb2 = 1'b0;

  word_t qa[$];
  word_t qb[$];

  lut_sweep_reader dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .busy(busy_a), .done(done_a),
    .lut_in(lut_in_a), .lut_out(lut_out_a), .m_data(m_data_a),
    .m_valid(m_valid_a), .m_ready(m_ready_a), .m_last(m_last_a)
  );

  lut_sweep_reader #(.LUT_LATENCY(2)) dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .busy(busy_b), .done(done_b),
    .lut_in(lut_in_b), .lut_out(lut_out_b), .m_data(m_data_b),
    .m_valid(m_valid_b), .m_ready(m_ready_b), .m_last(m_last_b)
  );

  // LUT contents under test: 0 parity bit, 1 zero-detect, 2 constant one, 3 msb, other random table
  function automatic logic ref_bit(int mode, int x);
    case (mode)
      0:       return (x % 2) == 1;
      1:       return x == 0;
      2:       return 1'b1;
      3:       return x >= 128;
      default: return tbl[x];
    endcase
  endfunction

  // Expected k-th stream word: data words hold 32 consecutive entries, optional count word last
  function automatic word_t exp_at(int mode, int k);
    word_t r;
    int    cnt;
    r.data = '0;
    r.last = 1'b0;
    if (k < 8) begin
      for (int j = 0; j < 32; j++) r.data[j] = ref_bit(mode, 32 * k + j);
      r.last = (k == 7) && !POP;
    end else begin
      cnt = 0;
      for (int x = 0; x < 256; x++) cnt += ref_bit(mode, x) ? 1 : 0;
      r.data = 32'(cnt);
      r.last = 1'b1;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  assign lut_out_a = ref_bit(mode_a, int'(lut_in_a));

  always @(posedge clk) begin
    sb1 <= ref_bit(mode_b, int'(lut_in_b));
    sb2 <= sb1;
  end
  assign lut_out_b = sb2;

  always @(posedge clk) begin
    #1;
    m_ready_a = ready_rand_a ? ($urandom_range(0, 99) < 30) : 1'b1;
    m_ready_b = ready_rand_b ? ($urandom_range(0, 99) < 30) : 1'b1;
  end

  // Monitor A: stream stability while stalled, frozen lut_in, scoreboard pop on handshake
  logic        pv_a = 1'b0, pr_a = 1'b0, prst_a = 1'b1, pl_a = 1'b0;
  logic [31:0] pd_a = '0;
  logic [7:0]  pli_a = '0;
  always @(negedge clk) begin
    word_t w;
    if (!prst_a && pv_a && !pr_a) begin
      chk("a_stall_valid", 32'(m_valid_a), 1);
      chk("a_stall_data", m_data_a, pd_a);
      chk("a_stall_last", 32'(m_last_a), 32'(pl_a));
    end
    if (!prst_a && pv_a && m_valid_a) chk("a_emit_lut_in", 32'(lut_in_a), 32'(pli_a));
    if (m_valid_a && m_ready_a && !rst_a) begin
      if (qa.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_extra_word: got data 0x%0h expected no word", m_data_a);
      end else begin
        w = qa.pop_front();
        chk("a_word_data", m_data_a, w.data);
        chk("a_word_last", 32'(m_last_a), 32'(w.last));
      end
    end
    pv_a = m_valid_a; pr_a = m_ready_a; prst_a = rst_a;
    pd_a = m_data_a;  pl_a = m_last_a;  pli_a = lut_in_a;
  end

  // Monitor B: same checks for the registered-LUT instance
  logic        pv_b = 1'b0, pr_b = 1'b0, prst_b = 1'b1, pl_b = 1'b0;
  logic [31:0] pd_b = '0;
  logic [7:0]  pli_b = '0;
  always @(negedge clk) begin
    word_t w;
    if (!prst_b && pv_b && !pr_b) begin
      chk("b_stall_valid", 32'(m_valid_b), 1);
      chk("b_stall_data", m_data_b, pd_b);
      chk("b_stall_last", 32'(m_last_b), 32'(pl_b));
    end
    if (!prst_b && pv_b && m_valid_b) chk("b_emit_lut_in", 32'(lut_in_b), 32'(pli_b));
    if (m_valid_b && m_ready_b && !rst_b) begin
      if (qb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_extra_word: got data 0x%0h expected no word", m_data_b);
      end else begin
        w = qb.pop_front();
        chk("b_word_data", m_data_b, w.data);
        chk("b_word_last", 32'(m_last_b), 32'(w.last));
      end
    end
    pv_b = m_valid_b; pr_b = m_ready_b; prst_b = rst_b;
    pd_b = m_data_b;  pl_b = m_last_b;  pli_b = lut_in_b;
  end

  // One sweep on A; extra_start_at > 0 pulses start again mid-sweep
  task automatic run_a(input int mode, input bit rnd, input int extra_start_at);
    int n;
    bit seen;
    for (int k = 0; k < NW; k++) qa.push_back(exp_at(mode, k));
    mode_a = mode;
    ready_rand_a = rnd;
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    n = 0;
    seen = 1'b0;
    while (n < 5000) begin
      @(negedge clk);
      n++;
      if (extra_start_at > 0) start_a = (n == extra_start_at);
      if (n == 1) chk("a_first_lut_in", 32'(lut_in_a), 0);
      if (done_a) begin
        seen = 1'b1;
        break;
      end
      chk("a_busy", 32'(busy_a), 1);
    end
    start_a = 1'b0;
    chk("a_done_seen", 32'(seen), 1);
    chk("a_busy_at_done", 32'(busy_a), 0);
    if (!rnd) chk("a_done_cycle", 32'(n), 32'(265 + int'(POP)));
    @(negedge clk);
    chk("a_done_pulse", 32'(done_a), 0);
    chk("a_idle_busy", 32'(busy_a), 0);
    chk("a_queue_drained", 32'(qa.size()), 0);
    qa.delete();
  endtask

  // One sweep on B; lut_in must step by one and dwell LUT_LATENCY+1 cycles per entry
  task automatic run_b(input int mode, input bit rnd);
    int n, cur, len;
    bit seen;
    for (int k = 0; k < NW; k++) qb.push_back(exp_at(mode, k));
    mode_b = mode;
    ready_rand_b = rnd;
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    n = 0; cur = 0; len = 0;
    seen = 1'b0;
    while (n < 5000) begin
      @(negedge clk);
      n++;
      if (done_b) begin
        seen = 1'b1;
        break;
      end
      chk("b_busy", 32'(busy_b), 1);
      if (int'(lut_in_b) == cur) len++;
      else begin
        chk("b_lut_in_step", 32'(lut_in_b), 32'(cur + 1));
        if (cur % 32 != 31) chk("b_hold_cycles", 32'(len), 3);
        else chk("b_hold_cycles_word_end", 32'(len >= 3), 1);
        cur = int'(lut_in_b);
        len = 1;
      end
    end
    chk("b_done_seen", 32'(seen), 1);
    chk("b_last_lut_in", 32'(cur), 255);
    if (!rnd) chk("b_done_cycle", 32'(n), 32'(777 + int'(POP)));
    @(negedge clk);
    chk("b_done_pulse", 32'(done_b), 0);
    chk("b_queue_drained", 32'(qb.size()), 0);
    qb.delete();
  endtask

  task automatic reset_mid_a();
    for (int k = 0; k < NW; k++) qa.push_back(exp_at(0, k));
    mode_a = 0;
    ready_rand_a = 1'b0;
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    repeat (40) @(negedge clk);
    chk("a_busy_before_rst", 32'(busy_a), 1);
    @(posedge clk); #1 rst_a = 1'b1;
    @(posedge clk); #1 rst_a = 1'b0;
    qa.delete();
    @(negedge clk);
    chk("a_rst_busy", 32'(busy_a), 0);
    chk("a_rst_done", 32'(done_a), 0);
    chk("a_rst_lut_in", 32'(lut_in_a), 0);
    chk("a_rst_m_data", m_data_a, 0);
    chk("a_rst_m_valid", 32'(m_valid_a), 0);
    chk("a_rst_m_last", 32'(m_last_a), 0);
    repeat (6) @(negedge clk);
    chk("a_rst_stays_idle", 32'(busy_a), 0);
    chk("a_rst_no_word", 32'(m_valid_a), 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) tbl[i] = 1'($urandom_range(0, 1));
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("a_reset_busy", 32'(busy_a), 0);
    chk("a_reset_done", 32'(done_a), 0);
    chk("a_reset_lut_in", 32'(lut_in_a), 0);
    chk("a_reset_m_data", m_data_a, 0);
    chk("a_reset_m_valid", 32'(m_valid_a), 0);
    chk("a_reset_m_last", 32'(m_last_a), 0);
    chk("b_reset_busy", 32'(busy_b), 0);
    chk("b_reset_done", 32'(done_b), 0);
    chk("b_reset_lut_in", 32'(lut_in_b), 0);
    chk("b_reset_m_data", m_data_b, 0);
    chk("b_reset_m_valid", 32'(m_valid_b), 0);
    chk("b_reset_m_last", 32'(m_last_b), 0);
    @(posedge clk); #1 rst_a = 1'b0; rst_b = 1'b0;

    run_a(0, 1'b0, 0);
    run_a(1, 1'b0, 0);
    run_a(2, 1'b0, 0);
    run_a(4, 1'b1, 0);
    run_a(0, 1'b1, 0);
    run_a(0, 1'b0, 100);
    reset_mid_a();
    run_a(1, 1'b0, 0);

    run_b(3, 1'b0);
    run_b(3, 1'b1);
    run_b(4, 1'b0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
